// File: rtl/rf_alu_seq.sv
// rf_alu_seq: multi-cycle controller that owns an 8-entry register file and
// a shared add/sub unit. One command is taken through a valid/ready
// handshake, its two sources are read on successive cycles, the result is
// computed and written back, and a one-cycle done pulse reports it.

module rf_alu_seq #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             done,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXEC
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_LDI = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    state_t           state;
    op_t              op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rf [NREG];
    logic [WIDTH:0]   exec_sum;
    logic [NREG-1:0]  wr_en;

    assign cmd_ready = (state == S_IDLE);
    assign dbg_data  = rf[dbg_addr];

    // Shared add/sub unit; bit WIDTH is the ADD carry or the SUB borrow.
    // The reserved opcode behaves exactly like LDI.
    always_comb begin
        exec_sum = '0;
        case (op_q)
            OP_ADD:  exec_sum = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  exec_sum = {1'b0, a_q} - {1'b0, b_q};
            default: exec_sum = {1'b0, imm_q};
        endcase
    end

    // One-hot write decode of the destination, enabled only in EXEC.
    always_comb begin
        wr_en = '0;
        if (state == S_EXEC) begin
            wr_en[rd_q] = 1'b1;
        end
    end

    // Register file storage; every entry is writable and clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    rf[i] <= exec_sum[WIDTH-1:0];
                end
            end
        end
    end

    // Sequencer: IDLE -> RDA -> RDB -> EXEC -> IDLE with registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_data  <= '0;
            res_carry <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= op_t'(cmd_op);
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                        imm_q <= cmd_imm;
                        state <= S_RDA;
                    end
                end
                S_RDA: begin
                    a_q   <= rf[rs1_q];
                    state <= S_RDB;
                end
                S_RDB: begin
                    b_q   <= rf[rs2_q];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_data  <= exec_sum[WIDTH-1:0];
                    res_carry <= exec_sum[WIDTH];
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
